// File: rtl/umult_pkg.sv
// Shared definitions for the unsigned sequential multiplier chain.
package umult_pkg;

   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} acc_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((32'd1 << res) < value) res = res + 1;
      return res;
   endfunction

   // Accumulator width that cannot overflow when summing `count` products of two w-bit operands
   function automatic int unsigned acc_width(input int unsigned w, input int unsigned count);
      return 2 * w + clog2(count);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned count);
      return clog2(count + 1);
   endfunction

endpackage

// File: rtl/umult_accumulator_if.sv
// Product-in / sum-out bundle between the multiplier, the accumulator and the result consumer.
interface umult_accumulator_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned COUNT = 4
);
   import umult_pkg::*;

   localparam int unsigned ACC_WIDTH = acc_width(WIDTH, COUNT);
   localparam int unsigned CNT_W     = cnt_width(COUNT);

   logic [2*WIDTH-1:0]   prod_in;
   logic                 prod_valid;
   logic                 clear;
   logic [ACC_WIDTH-1:0] sum_out;
   logic                 sum_valid;
   logic                 sum_ready;
   logic [CNT_W-1:0]     count_out;
   logic                 drop_flag;

   modport master (
      output prod_in, prod_valid, clear, sum_ready,
      input  sum_out, sum_valid, count_out, drop_flag
   );

   modport slave (
      input  prod_in, prod_valid, clear, sum_ready,
      output sum_out, sum_valid, count_out, drop_flag
   );

endinterface

// File: rtl/umult_rise_detect.sv
// Rising-edge detector for level-held valids; the registered copy resets high so a stale level is ignored.
module umult_rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (rst) d_q <= 1'b1;
      else     d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/umult_accumulator.sv
// Sums COUNT multiplier products per result, with a one-deep pend slot while the result waits downstream.
module umult_accumulator
   import umult_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned COUNT = 4
) (
   input logic                clk,
   input logic                rst,
   umult_accumulator_if.slave bus
);

   localparam int unsigned ACC_WIDTH = acc_width(WIDTH, COUNT);
   localparam int unsigned CNT_W     = cnt_width(COUNT);

   acc_state_t           state;
   acc_state_t           state_next;
   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_W-1:0]     cnt;
   logic [2*WIDTH-1:0]   pend_data;
   logic                 pend_full;
   logic                 drop_flag;
   logic                 capture;

   logic accum_en;
   logic xfer_en;
   logic pend_load;
   logic drop_set;

   umult_rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.prod_valid),
      .rise (capture)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (bus.clear) begin
         state_next = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (capture && cnt == CNT_W'(COUNT - 1)) state_next = DONE;
            DONE:    if (bus.sum_ready) state_next = ACCUM;
            default: state_next = ACCUM;
         endcase
      end
   end

   // Datapath strobes; clear suppresses every one of them
   always_comb begin
      accum_en  = 1'b0;
      xfer_en   = 1'b0;
      pend_load = 1'b0;
      drop_set  = 1'b0;
      if (!bus.clear) begin
         accum_en  = (state == ACCUM) && capture;
         xfer_en   = (state == DONE) && bus.sum_ready;
         pend_load = (state == DONE) && !bus.sum_ready && capture && !pend_full;
         drop_set  = (state == DONE) && capture && pend_full;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         acc       <= '0;
         cnt       <= '0;
         pend_data <= '0;
         pend_full <= 1'b0;
         drop_flag <= 1'b0;
      end else begin
         if (accum_en) begin
            acc <= acc + ACC_WIDTH'(bus.prod_in);
            cnt <= cnt + CNT_W'(1);
         end
         // A capture landing on the transfer edge with pend empty goes straight in as the first term
         if (xfer_en) begin
            pend_full <= 1'b0;
            if (pend_full) begin
               acc <= ACC_WIDTH'(pend_data);
               cnt <= CNT_W'(1);
            end else if (capture) begin
               acc <= ACC_WIDTH'(bus.prod_in);
               cnt <= CNT_W'(1);
            end else begin
               acc <= '0;
               cnt <= '0;
            end
         end
         if (pend_load) begin
            pend_data <= bus.prod_in;
            pend_full <= 1'b1;
         end
         if (drop_set) drop_flag <= 1'b1;
      end
   end

   assign bus.sum_out   = acc;
   assign bus.sum_valid = (state == DONE);
   assign bus.count_out = cnt;
   assign bus.drop_flag = drop_flag;

endmodule

// File: tb/tb_umult_accumulator.sv
// Directed bench for umult_accumulator with a cycle-level reference model and per-cycle comparison.
module tb_umult_accumulator;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned COUNT = 4;

   logic clk;
   logic rst;

   umult_accumulator_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

   umult_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: terms of the current sum, completion flag, one waiting product, sticky loss
   int m_acc, m_cnt, m_pend;
   bit m_done, m_pend_full, m_drop, m_prev;
   bit started = 1'b0;

   always @(posedge clk) begin
      bit cap;
      started = 1'b1;
      if (rst) begin
         m_acc = 0; m_cnt = 0; m_done = 0; m_pend_full = 0; m_drop = 0; m_prev = 1;
      end else begin
         cap    = bus.prod_valid && !m_prev;
         m_prev = bus.prod_valid;
         if (bus.clear) begin
            m_acc = 0; m_cnt = 0; m_done = 0; m_pend_full = 0; m_drop = 0;
         end else if (!m_done) begin
            if (cap) begin
               m_acc = m_acc + int'(bus.prod_in);
               m_cnt = m_cnt + 1;
               if (m_cnt == COUNT) m_done = 1;
            end
         end else if (bus.sum_ready) begin
            m_done = 0;
            if (m_pend_full) begin
               m_acc = m_pend; m_cnt = 1;
               if (cap) m_drop = 1;
            end else if (cap) begin
               m_acc = int'(bus.prod_in); m_cnt = 1;
            end else begin
               m_acc = 0; m_cnt = 0;
            end
            m_pend_full = 0;
         end else if (cap) begin
            if (m_pend_full) m_drop = 1;
            else begin
               m_pend = int'(bus.prod_in); m_pend_full = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         total = total + 1;
         if (int'(bus.sum_out) != m_acc || bus.sum_valid != m_done ||
             int'(bus.count_out) != m_cnt || bus.drop_flag != m_drop) begin
            bad = bad + 1;
            $display("FAIL model t=%0t: sum=%0d valid=%0b cnt=%0d drop=%0b, want sum=%0d valid=%0b cnt=%0d drop=%0b",
                     $time, bus.sum_out, bus.sum_valid, bus.count_out, bus.drop_flag,
                     m_acc, m_done, m_cnt, m_drop);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int value, input int hi, input int lo);
      bus.prod_in    = 8'(value);
      bus.prod_valid = 1'b1;
      tick(hi);
      bus.prod_valid = 1'b0;
      tick(lo);
   endtask

   initial begin
      rst            = 1'b1;
      bus.prod_in    = '0;
      bus.prod_valid = 1'b0;
      bus.clear      = 1'b0;
      bus.sum_ready  = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      check("reset_sum", int'(bus.sum_out), 0);
      check("reset_valid", int'(bus.sum_valid), 0);
      check("reset_cnt", int'(bus.count_out), 0);

      // Four 15x15 products
      for (int i = 0; i < 3; i++) pulse(225, 3, 2);
      bus.prod_in    = 8'd225;
      bus.prod_valid = 1'b1;
      tick(1);
      check("fourth_edge_valid", int'(bus.sum_valid), 1);
      check("fourth_edge_sum", int'(bus.sum_out), 900);
      tick(2);
      bus.prod_valid = 1'b0;
      tick(2);
      check("cnt_done", int'(bus.count_out), 4);

      // Backpressure holds the result
      tick(10);
      check("held_sum", int'(bus.sum_out), 900);
      check("held_valid", int'(bus.sum_valid), 1);
      bus.sum_ready = 1'b1;
      tick(1);
      bus.sum_ready = 1'b0;
      check("xfer_valid", int'(bus.sum_valid), 0);
      check("xfer_cnt", int'(bus.count_out), 0);

      // Ready while idle has no effect
      bus.sum_ready = 1'b1;
      tick(2);
      bus.sum_ready = 1'b0;

      // Stale valid across reset release is ignored
      bus.prod_in    = 8'd49;
      bus.prod_valid = 1'b1;
      rst            = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(3);
      check("stale_cnt", int'(bus.count_out), 0);
      bus.prod_valid = 1'b0;
      tick(2);
      pulse(6, 3, 2);
      check("after_stale_sum", int'(bus.sum_out), 6);
      check("after_stale_cnt", int'(bus.count_out), 1);

      // Complete sum, then two products while waiting: first pends, second drops
      pulse(10, 2, 2);
      pulse(20, 2, 2);
      pulse(30, 2, 2);
      check("sum66", int'(bus.sum_out), 66);
      pulse(100, 2, 2);
      pulse(20, 2, 2);
      check("drop_set", int'(bus.drop_flag), 1);
      check("sum66_held", int'(bus.sum_out), 66);
      bus.sum_ready = 1'b1;
      tick(1);
      bus.sum_ready = 1'b0;
      check("pend_cnt", int'(bus.count_out), 1);
      check("pend_sum", int'(bus.sum_out), 100);
      check("drop_sticky", int'(bus.drop_flag), 1);

      // Clear, two captures, clear colliding with a third edge
      bus.clear = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      check("clear_drop", int'(bus.drop_flag), 0);
      pulse(3, 2, 2);
      pulse(4, 2, 2);
      check("two_sum", int'(bus.sum_out), 7);
      bus.prod_in    = 8'd9;
      bus.prod_valid = 1'b1;
      bus.clear      = 1'b1;
      tick(1);
      bus.clear = 1'b0;
      check("clear_sum", int'(bus.sum_out), 0);
      check("clear_cnt", int'(bus.count_out), 0);
      tick(2);
      bus.prod_valid = 1'b0;
      tick(2);
      for (int i = 0; i < 4; i++) pulse(1, 2, 2);
      check("ones_sum", int'(bus.sum_out), 4);
      check("ones_valid", int'(bus.sum_valid), 1);

      // Transfer and capture on the same edge
      bus.prod_in    = 8'd7;
      bus.prod_valid = 1'b1;
      bus.sum_ready  = 1'b1;
      tick(1);
      bus.sum_ready = 1'b0;
      check("same_edge_valid", int'(bus.sum_valid), 0);
      check("same_edge_cnt", int'(bus.count_out), 1);
      check("same_edge_sum", int'(bus.sum_out), 7);
      tick(2);
      bus.prod_valid = 1'b0;
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/umult_accumulator.md
# umult_accumulator

Downstream stage of the unsigned sequential multiplier: consumes each finished product and sums a fixed number of them, COUNT, into a dot-product result. It detects completion from the multiplier's level-held valid by rising-edge detection and holds one product arriving early. The completed sum is offered downstream over a valid/ready handshake. Sits between the multiplier's Z/valid_out pins and the result consumer.

## Interface
- WIDTH, 4: multiplier operand width; products are 2*WIDTH bits
- COUNT, 4: products per sum, ≥2
- ACC_WIDTH, 2*WIDTH+clog2(COUNT): derived, not overridden; sized so the sum never overflows
- CNT_W, clog2(COUNT+1): derived
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- prod_in  in  2*WIDTH  product (multiplier Z)
- prod_valid  in  1  multiplier valid_out; level, stays high until the next multiply starts
- clear  in  1  synchronous abort of the current sum
- sum_out  out  ACC_WIDTH  accumulated result
- sum_valid  out  1  sum_out holds a completed sum
- sum_ready  in  1  consumer accepts sum_out
- count_out  out  CNT_W  products accumulated in the current sum
- drop_flag  out  1  sticky: a product was lost

## Operation
- Capture event: prod_valid=1 and prod_valid_q=0, where prod_valid_q is prod_valid registered one cycle. Only the rising edge counts; a held level never counts twice.
- States:
  - ACCUM: on capture, acc += prod_in and cnt++. A capture that brings cnt to COUNT moves to DONE.
  - DONE: sum_valid=1 and acc is frozen.
    - A capture in DONE loads the pend register if it is empty.
    - A capture in DONE with pend full sets drop_flag and discards the product.
    - When sum_valid and sum_ready are both high, the sum transfers. The block returns to ACCUM with acc=pend_data and cnt=1 if pend was full, otherwise acc=0 and cnt=0. pend is emptied.
- clear forces ACCUM, acc=0, cnt=0, pend empty, drop_flag=0.
  - clear has priority over a capture and over a transfer in the same cycle; both are discarded.
  - clear does not reset prod_valid_q.
- Width rule: prod_in is zero-extended to ACC_WIDTH. No overflow is possible, so there is no overflow output.
- sum_out=acc at all times. It is meaningful only while sum_valid=1.

## Timing
- Reset values:
  - state=ACCUM, sum_out=0, sum_valid=0, count_out=0, drop_flag=0, pend empty.
  - prod_valid_q=1, so a valid still high at reset exit (a stale result) is not counted.
- Capture latency: prod_in is sampled at the edge where the capture condition holds. acc and count_out update at that edge and are visible the next cycle.
- sum_valid rises the cycle after the COUNTth capture.
- While sum_valid=1 and sum_ready=0, sum_out is stable and sum_valid stays high.
- Transfer occurs at the edge where both are high. sum_valid is 0 the next cycle unless COUNT=1, which is disallowed.
- sum_ready while sum_valid=0 has no effect.
- A capture in the same cycle as a transfer goes to pend. It becomes the first term of the next sum, giving cnt=1 and acc=prod_in.
- Minimum spacing between captures is 2 cycles, because an edge requires a low cycle. The multiplier's own latency exceeds this.
- rst mid-sum discards everything. The first product counted after reset is the next true rising edge.

## Structure
- Shared package umult_pkg holds:
  - clog2 constant function
  - state enum {ACCUM, DONE}
  - ACC_WIDTH/CNT_W derivation helper, reusable by other multiplier-chain stages
- One sub-module: umult_rise_detect (clk, rst, d, rise). It holds the registered copy with reset value 1. It is reused wherever level-valid multiplier outputs are consumed.
- Core logic is a single state register plus acc, cnt, pend_data, pend_full and drop_flag registers.

## Test plan
- WIDTH=4, COUNT=4, rst then four products of 225 (15×15), each as a valid pulse 3 cycles high, 2 cycles low → sum_out=900, sum_valid=1 the cycle after the 4th edge, count_out=4.
- Hold sum_ready=0 for 10 cycles after completion → sum_valid and sum_out=900 stable. Then sum_ready=1 for one cycle → sum_valid=0 next cycle, count_out=0.
- prod_valid held high across rst release with prod_in=49 → not counted, count_out=0. The next rising edge with 6 → acc=6.
- Two products (100, 20) arrive while in DONE with sum_ready=0 → 100 held in pend, 20 dropped, drop_flag=1. After the transfer, count_out=1 and sum_out=100.
- Two captures, then clear asserted in the same cycle as a third edge → acc=0, count_out=0, drop_flag=0. The following four products of 1 → sum_out=4.
- Transfer and capture of 7 in the same cycle → next cycle sum_valid=0, count_out=1, sum_out=7.
